// File: rtl/fpu_add_align.sv
// ============================================================================
// Module      : fpu_add_align
// Description : Iterative exponent alignment and mantissa add/subtract stage
//               for single-precision FP add/sub (one bit of shift per cycle).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_add_align #(
  parameter int MAX_SHIFT = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_mantissa,
  output logic [7:0]  out_exponent,
  output logic        out_sign,
  output logic        out_sticky,
  output logic        out_zero,
  output logic        out_overflow,
  output logic        out_special
);

  localparam int CNT_W = $clog2(MAX_SHIFT + 1);
  localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_SHIFT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALIGN = 2'd1;
  localparam logic [1:0] S_ADD   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [23:0]      r_mant_l;
  logic [23:0]      r_mant_s;
  logic [7:0]       r_exp_l;
  logic [7:0]       r_diff;
  logic [CNT_W-1:0] r_shift_cnt;
  logic             r_sticky;
  logic             r_sign_l;
  logic             r_eff_sub;
  logic             r_special;

  // Operand decode: zero exponent flushes the operand (no hidden bit).
  logic [7:0]  w_exp_a, w_exp_b;
  logic [23:0] w_mant_a, w_mant_b;
  logic        w_sign_a, w_sign_b;
  logic        w_a_is_l;

  assign w_exp_a  = op_a[30:23];
  assign w_exp_b  = op_b[30:23];
  assign w_mant_a = (w_exp_a == 8'd0) ? 24'd0 : {1'b1, op_a[22:0]};
  assign w_mant_b = (w_exp_b == 8'd0) ? 24'd0 : {1'b1, op_b[22:0]};
  assign w_sign_a = op_a[31];
  assign w_sign_b = op_b[31] ^ op_sub;
  assign w_a_is_l = {w_exp_a, w_mant_a} >= {w_exp_b, w_mant_b};

  assign in_ready = (r_state == S_IDLE);

  logic [24:0] w_sum;
  logic [23:0] w_res_mant;
  logic [7:0]  w_res_exp;
  logic        w_res_sticky;
  logic        w_res_ovf;
  logic        w_res_zero;

  assign w_sum = {1'b0, r_mant_l} + {1'b0, r_mant_s};

  always_comb begin
    w_res_mant   = r_mant_l - r_mant_s;
    w_res_exp    = r_exp_l;
    w_res_sticky = r_sticky;
    w_res_ovf    = 1'b0;
    if (!r_eff_sub) begin
      if (w_sum[24]) begin
        w_res_mant   = w_sum[24:1];
        w_res_sticky = r_sticky | w_sum[0];
        w_res_exp    = r_exp_l + 8'd1;
        w_res_ovf    = (r_exp_l == 8'd254);
      end else begin
        w_res_mant   = w_sum[23:0];
      end
    end
  end

  assign w_res_zero = (w_res_mant == 24'd0) && !w_res_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mant_l     <= 24'd0;
      r_mant_s     <= 24'd0;
      r_exp_l      <= 8'd0;
      r_diff       <= 8'd0;
      r_shift_cnt  <= '0;
      r_sticky     <= 1'b0;
      r_sign_l     <= 1'b0;
      r_eff_sub    <= 1'b0;
      r_special    <= 1'b0;
      out_valid    <= 1'b0;
      out_mantissa <= 24'd0;
      out_exponent <= 8'd0;
      out_sign     <= 1'b0;
      out_sticky   <= 1'b0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_special  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_a_is_l) begin
              r_mant_l <= w_mant_a;
              r_mant_s <= w_mant_b;
              r_exp_l  <= w_exp_a;
              r_diff   <= w_exp_a - w_exp_b;
              r_sign_l <= w_sign_a;
            end else begin
              r_mant_l <= w_mant_b;
              r_mant_s <= w_mant_a;
              r_exp_l  <= w_exp_b;
              r_diff   <= w_exp_b - w_exp_a;
              r_sign_l <= w_sign_b;
            end
            r_eff_sub   <= w_sign_a ^ w_sign_b;
            r_special   <= (w_exp_a == 8'hFF) || (w_exp_b == 8'hFF);
            r_shift_cnt <= '0;
            r_sticky    <= 1'b0;
            r_state     <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          // The shift cap bounds latency; beyond it the operand is all zero.
          if (r_diff == 8'd0 || r_shift_cnt == c_MAX_CNT) begin
            r_state <= S_ADD;
          end else begin
            r_sticky    <= r_sticky | r_mant_s[0];
            r_mant_s    <= r_mant_s >> 1;
            r_diff      <= r_diff - 8'd1;
            r_shift_cnt <= r_shift_cnt + 1'b1;
          end
        end
        S_ADD: begin
          out_mantissa <= w_res_mant;
          out_sticky   <= w_res_sticky;
          out_overflow <= w_res_ovf;
          out_zero     <= w_res_zero;
          out_exponent <= w_res_zero ? 8'd0 : w_res_exp;
          out_sign     <= w_res_zero ? 1'b0 : r_sign_l;
          out_special  <= r_special;
          out_valid    <= 1'b1;
          r_state      <= S_DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_add_align.sv
// ============================================================================
// Module      : tb_fpu_add_align
// Description : Directed, table-driven self-checking bench for fpu_add_align.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_add_align;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mantissa;
  logic [7:0]  out_exponent;
  logic        out_sign;
  logic        out_sticky;
  logic        out_zero;
  logic        out_overflow;
  logic        out_special;

  fpu_add_align #(.MAX_SHIFT(25)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_sub       (op_sub),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_mantissa (out_mantissa),
    .out_exponent (out_exponent),
    .out_sign     (out_sign),
    .out_sticky   (out_sticky),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .out_special  (out_special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    int          lat;
    logic        full;
    logic [23:0] mant;
    logic [7:0]  expo;
    logic        sign;
    logic        sticky;
    logic        zero;
    logic        ovf;
    logic        special;
  } vec_t;

  int tests;
  int fails;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operation, return the number of edges from accept to out_valid.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       output int n);
    bit got;
    @(negedge clk);
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0; got = 0;
    while (!got && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) got = 1;
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready_back"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk) out_ready = 1'b0;
  endtask

  initial begin
    int n;
    string t;
    logic [23:0] hm;
    logic [7:0]  he;
    bit          stable;
    bit          seen;

    tests = 0; fails = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = 32'd0; op_b = 32'd0; op_sub = 1'b0;

    //          a             b             sub lat full mant        exp    s  st z  ov sp
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 0, 2,  1, 24'h800000, 8'd128, 0, 0, 0, 0, 0};
    vecs[1]  = '{32'h3F800000, 32'h3F000000, 0, 3,  1, 24'hC00000, 8'd127, 0, 0, 0, 0, 0};
    vecs[2]  = '{32'h40400000, 32'h40400000, 1, 2,  1, 24'h000000, 8'd0,   0, 0, 1, 0, 0};
    vecs[3]  = '{32'h3F800000, 32'h33800001, 0, 26, 1, 24'h800000, 8'd127, 0, 1, 0, 0, 0};
    vecs[4]  = '{32'h3F800000, 32'h00800000, 0, 27, 1, 24'h800000, 8'd127, 0, 1, 0, 0, 0};
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2,  1, 24'hFFFFFF, 8'd255, 0, 0, 0, 1, 0};
    vecs[6]  = '{32'h7F800000, 32'h3F800000, 0, 27, 0, 24'h000000, 8'd0,   0, 0, 0, 0, 1};
    vecs[7]  = '{32'h3F800000, 32'h40000000, 1, 3,  1, 24'h400000, 8'd128, 1, 0, 0, 0, 0};
    vecs[8]  = '{32'hBF800000, 32'h3F800000, 0, 2,  1, 24'h000000, 8'd0,   0, 0, 1, 0, 0};
    vecs[9]  = '{32'h00000000, 32'h3F800000, 0, 27, 1, 24'h800000, 8'd127, 0, 0, 0, 0, 0};
    vecs[10] = '{32'h3F800000, 32'h3FC00000, 1, 2,  1, 24'h400000, 8'd127, 1, 0, 0, 0, 0};
    vecs[11] = '{32'h40000000, 32'h3F800001, 1, 3,  1, 24'h400000, 8'd128, 0, 1, 0, 0, 0};

    #12;
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_mantissa", {8'd0, out_mantissa}, 32'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, n);
      t = $sformatf("v%0d", i);
      check({t, " latency"}, n, vecs[i].lat);
      if (vecs[i].full) begin
        check({t, " mantissa"}, {8'd0, out_mantissa}, {8'd0, vecs[i].mant});
        check({t, " exponent"}, {24'd0, out_exponent}, {24'd0, vecs[i].expo});
        check({t, " sign"}, {31'd0, out_sign}, {31'd0, vecs[i].sign});
        check({t, " sticky"}, {31'd0, out_sticky}, {31'd0, vecs[i].sticky});
        check({t, " zero"}, {31'd0, out_zero}, {31'd0, vecs[i].zero});
        check({t, " overflow"}, {31'd0, out_overflow}, {31'd0, vecs[i].ovf});
      end
      check({t, " special"}, {31'd0, out_special}, {31'd0, vecs[i].special});
      release_result(t);
    end

    // Back-pressure: result holds, in_ready low, new operands ignored.
    issue(32'h3F800000, 32'h3F000000, 1'b0, n);
    check("hold latency", n, 3);
    hm = out_mantissa; he = out_exponent;
    stable = 1'b1;
    @(negedge clk);
    op_a = 32'h40400000; op_b = 32'h40400000; op_sub = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || out_mantissa != hm || out_exponent != he) stable = 1'b0;
    end
    check("hold stable", {31'd0, stable}, 32'd1);
    check("hold mantissa", {8'd0, out_mantissa}, 32'h00C00000);
    @(negedge clk) in_valid = 1'b0;
    release_result("hold");
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("ignored no_result", {31'd0, seen}, 32'd0);

    // Reset while aligning (d=10) discards the operation.
    @(negedge clk);
    op_a = 32'h3F800000; op_b = 32'h3A800000; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst no_result", {31'd0, seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_add_align.md
Name: fpu_add_align

Overview:
Iterative exponent-alignment and mantissa add/subtract stage for single-precision FP add/sub. It accepts two IEEE-754 operands and outputs an unnormalized 24-bit mantissa and 8-bit exponent. Those outputs feed fpu_normalizer's mantissa/exponent inputs directly. The block has one operation in flight, with valid/ready handshakes on input and output, and right-shifts the smaller operand one bit per cycle.

Parameters:
MAX_SHIFT, 25, maximum alignment shifts; exponent differences above this are clamped (the result is identical because the mantissa is fully shifted out).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept; equals (state==IDLE), combinational
op_a  input  32  IEEE-754 single operand A
op_b  input  32  IEEE-754 single operand B
op_sub  input  1  1 = A-B, 0 = A+B
out_valid  output  1  result valid, registered
out_ready  input  1  downstream accepts result
out_mantissa  output  24  aligned sum/difference with hidden bit at [23]; may be unnormalized
out_exponent  output  8  exponent of larger operand, +1 on carry
out_sign  output  1  result sign
out_sticky  output  1  OR of all bits shifted out
out_zero  output  1  exact zero result
out_overflow  output  1  carry pushed exponent to 255
out_special  output  1  either operand exponent == 255 (inf/NaN; other outputs don't-care)

Behaviour:
- Reset (async, any state): state=IDLE, all registered outputs 0, in_ready=1. A reset mid-operation discards the operation; no out_valid follows.
- Operand decode:
  - exp==0 flushes the operand to zero (mantissa 0, no hidden bit).
  - Otherwise mantissa = {1, frac[22:0]}.
  - Effective B sign = sign_b ^ op_sub.
- IDLE: on in_valid && in_ready, capture both operands.
  - Larger operand L: higher exponent; if exponents are equal, higher mantissa; if fully equal, A.
  - diff = exp_L - exp_S; shift_cnt = 0; sticky = 0.
  - Next state ALIGN.
- ALIGN, each cycle:
  - If diff==0 or shift_cnt==MAX_SHIFT: go to ADD.
  - Else: sticky |= mant_S[0]; mant_S >>= 1; diff--; shift_cnt++.
- ADD, one cycle:
  - Same effective sign: sum = mant_L + mant_S (25 bits).
    - If sum[24]: mantissa = sum[24:1], sticky |= sum[0], exponent = exp_L+1, overflow = (exp_L+1==255).
    - Else: mantissa = sum[23:0], exponent = exp_L.
  - Different effective sign: mantissa = mant_L - mant_S (never negative), exponent = exp_L.
  - Sign = sign of L.
  - Zero result: mantissa==0 && sticky==0 → out_zero=1, sign=0, exponent=0.
  - Load outputs; out_valid=1; next state DONE.
- DONE: outputs held stable while out_ready=0. On out_ready: out_valid=0 next edge, state IDLE. in_ready stays 0 until IDLE is reached; there is no same-cycle accept.
- Latency: the accept edge to the out_valid rising edge is 2 + min(d, MAX_SHIFT) clocks, where d = initial exponent difference.
- in_valid while not IDLE is ignored; the operands are not captured.
- out_special is computed at capture and reported with the result; the normal flow and latency are unchanged.

Test Plan:
- 1.0+1.0: op_a=op_b=0x3F800000, op_sub=0 → after 2 clocks: out_mantissa=0x800000, out_exponent=128, sign=0, sticky=0, zero=0.
- 1.0+0.5: op_a=0x3F800000, op_b=0x3F000000 → after 3 clocks: mantissa=0xC00000, exponent=127, sticky=0.
- Cancellation: op_a=op_b=0x40400000, op_sub=1 → after 2 clocks: out_zero=1, mantissa=0, exponent=0, sign=0.
- Large diff: op_a=0x3F800000, op_b=0x33800001 (d=24) → after 26 clocks: mantissa=0x800000, exponent=127, sticky=1.
  - Same operands with op_b=0x00800000 (d=126): clamped, out_valid after 27 clocks.
- Overflow/special:
  - 0x7F7FFFFF+0x7F7FFFFF → exponent=255, out_overflow=1, mantissa=0xFFFFFF.
  - op_a=0x7F800000 → out_special=1.
- Handshake/reset:
  - Hold out_ready=0 for 5 clocks → outputs stable, in_ready=0, new in_valid ignored; raise out_ready → out_valid=0 next clock, in_ready=1.
  - Assert rst during ALIGN with d=10 → in_ready=1 and out_valid=0 immediately; no result afterwards.
